// File: rtl/cam_wr_burst.sv
`default_nettype none
// ============================================================================
// Module   : cam_wr_burst
// Purpose  : Buffers camera pixels in a small FIFO and hands them to a memory
//            controller as fixed-length write bursts. Frames are written in
//            two banks (ping-pong), and the reader bank flips only after a
//            complete, clean frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   cmos_pclk    in   1   sole clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   cmos_vsyn    in   1   vertical sync, high between frames
//   data_16b     in  16   pixel word
//   data_16b_en  in   1   pixel word qualifier
//   wr_req       out  1   burst write request
//   wr_addr      out 22   burst start word address
//   wr_ack       in   1   one-cycle grant of the pending request
//   wr_data      out 16   FIFO head word (first-word-fall-through)
//   wr_data_rd   in   1   pop strobe during a granted burst
//   frame_done   out  1   one-cycle pulse per completed clean frame
//   rd_bank      out  1   bank holding the latest complete frame
//   ovf          out  1   sticky FIFO overflow flag
// ============================================================================
module cam_wr_burst #(
  parameter int BURST_LEN    = 64,
  parameter int FIFO_DEPTH   = 256,
  parameter int FRAME_PIXELS = 307200,
  parameter int FRAME_STRIDE = 524288
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsyn,
  input  logic [15:0] data_16b,
  input  logic        data_16b_en,
  output logic        wr_req,
  output logic [21:0] wr_addr,
  input  logic        wr_ack,
  output logic [15:0] wr_data,
  input  logic        wr_data_rd,
  output logic        frame_done,
  output logic        rd_bank,
  output logic        ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN);

  localparam logic [AW:0]   FIFO_FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   BURST_FILL    = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]   PTR_ONE       = (AW+1)'(1);
  localparam logic [BW-1:0] BURST_LAST    = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] BCNT_ONE      = BW'(1);
  localparam logic [21:0]   BURST_WORDS   = 22'(BURST_LEN);
  localparam logic [21:0]   FRAME_WORDS   = 22'(FRAME_PIXELS);
  localparam logic [21:0]   FRAME_LAST    = 22'(FRAME_PIXELS - 1);
  localparam logic [21:0]   STRIDE        = 22'(FRAME_STRIDE);
  localparam logic [21:0]   CNT_ONE       = 22'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t        state;

  // vsync edge detector
  logic          vs_q1;
  logic          vs_q2;
  logic          sof;
  logic          sof_pend;
  logic          sof_apply;

  // pixel window
  logic          frame_active;
  logic          frame_bad;
  logic [21:0]   pix_cnt;
  logic          accept;
  logic          push;
  logic          drop;

  // FIFO
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   fill;
  logic          full;
  logic          pop;

  // burst / frame bookkeeping
  logic [BW-1:0] burst_cnt;
  logic [21:0]   offset;
  logic [21:0]   next_off;
  logic          wr_bank;
  logic          burst_done;
  logic          frame_end;

  assign sof = vs_q1 & ~vs_q2;

  // A frame start seen mid-burst is parked in sof_pend and carried out once
  // the FSM has left XFER, so the granted burst always drains intact.
  assign sof_apply = (sof | sof_pend) & (state != XFER);

  // Pixels are held off while a frame start is outstanding so that nothing
  // of the new frame lands in the FIFO before the flush.
  assign accept = data_16b_en & frame_active & ~sof & ~sof_pend;

  assign fill = wptr - rptr;
  assign full = (fill == FIFO_FULL_LVL);
  assign push = accept & ~full;
  assign drop = accept & full;
  assign pop  = (state == XFER) & wr_data_rd & (fill != '0);

  assign burst_done = pop & (burst_cnt == BURST_LAST);
  assign next_off   = offset + BURST_WORDS;
  assign frame_end  = burst_done & (next_off == FRAME_WORDS);

  // Head word is forced to zero when empty so a flushed or reset FIFO never
  // shows stale memory contents.
  assign wr_data = (fill == '0) ? 16'h0000 : mem[rptr[AW-1:0]];

  // FIFO storage: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge cmos_pclk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= data_16b;
    end
  end

  // Input side: vsync sync, pixel window, FIFO pointers, overflow tracking.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q1        <= 1'b0;
      vs_q2        <= 1'b0;
      frame_active <= 1'b0;
      frame_bad    <= 1'b0;
      pix_cnt      <= '0;
      wptr         <= '0;
      rptr         <= '0;
      ovf          <= 1'b0;
    end else begin
      vs_q1 <= cmos_vsyn;
      vs_q2 <= vs_q1;
      if (sof_apply) begin
        pix_cnt      <= '0;
        frame_active <= 1'b1;
        frame_bad    <= 1'b0;
        wptr         <= '0;
        rptr         <= '0;
      end else begin
        if (accept) begin
          pix_cnt <= pix_cnt + CNT_ONE;
          if (pix_cnt == FRAME_LAST) begin
            frame_active <= 1'b0;
          end
        end
        if (drop) begin
          ovf       <= 1'b1;
          frame_bad <= 1'b1;
        end
        if (push) begin
          wptr <= wptr + PTR_ONE;
        end
        if (pop) begin
          rptr <= rptr + PTR_ONE;
        end
      end
    end
  end

  // Burst FSM with registered request, address and frame outputs.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      rd_bank    <= 1'b1;
      wr_bank    <= 1'b0;
      offset     <= '0;
      burst_cnt  <= '0;
      sof_pend   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sof && (state == XFER)) begin
        sof_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sof_apply) begin
            offset   <= '0;
            sof_pend <= 1'b0;
          end else if (fill >= BURST_FILL) begin
            state   <= REQ;
            wr_req  <= 1'b1;
            wr_addr <= (wr_bank ? STRIDE : 22'd0) + offset;
          end
        end
        REQ: begin
          // A new frame start withdraws the request: its data is flushed.
          if (sof_apply) begin
            offset   <= '0;
            sof_pend <= 1'b0;
            state    <= IDLE;
            wr_req   <= 1'b0;
          end else if (wr_ack) begin
            state     <= XFER;
            wr_req    <= 1'b0;
            burst_cnt <= '0;
          end
        end
        XFER: begin
          if (pop) begin
            burst_cnt <= burst_cnt + BCNT_ONE;
          end
          if (burst_done) begin
            state     <= IDLE;
            burst_cnt <= '0;
            if (frame_end) begin
              offset <= '0;
              if (!frame_bad) begin
                frame_done <= 1'b1;
                rd_bank    <= wr_bank;
                wr_bank    <= ~wr_bank;
              end
            end else begin
              offset <= next_off;
            end
          end
        end
        default: begin
          state  <= IDLE;
          wr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_wr_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_wr_burst
// Purpose  : Directed self-checking bench for cam_wr_burst, run with a small
//            geometry (burst 8, FIFO 16, frame 32 words, stride 1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_wr_burst;

  logic        cmos_pclk = 1'b0;
  logic        rst_n;
  logic        cmos_vsyn;
  logic [15:0] data_16b;
  logic        data_16b_en;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic        wr_ack;
  logic [15:0] wr_data;
  logic        wr_data_rd;
  logic        frame_done;
  logic        rd_bank;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  cam_wr_burst #(
    .BURST_LEN   (8),
    .FIFO_DEPTH  (16),
    .FRAME_PIXELS(32),
    .FRAME_STRIDE(1024)
  ) dut (
    .cmos_pclk  (cmos_pclk),
    .rst_n      (rst_n),
    .cmos_vsyn  (cmos_vsyn),
    .data_16b   (data_16b),
    .data_16b_en(data_16b_en),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_ack     (wr_ack),
    .wr_data    (wr_data),
    .wr_data_rd (wr_data_rd),
    .frame_done (frame_done),
    .rd_bank    (rd_bank),
    .ovf        (ovf)
  );

  always #5 cmos_pclk = ~cmos_pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge cmos_pclk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    cmos_vsyn = 1'b1;
    tick(3);
    cmos_vsyn = 1'b0;
    tick(1);
  endtask

  task automatic send_pixel(input logic [15:0] v);
    data_16b    = v;
    data_16b_en = 1'b1;
    tick(1);
    data_16b_en = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !wr_req; i++) tick(1);
    check(tag, {31'd0, wr_req}, 32'd1);
  endtask

  task automatic grant(input string tag);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    check(tag, {31'd0, wr_req}, 32'd0);
  endtask

  // Pop n words expecting first, first+1, ...; alt inserts an idle cycle.
  task automatic pop_n(input string tag, input logic [15:0] first, input int n, input bit alt);
    for (int i = 0; i < n; i++) begin
      check(tag, {16'd0, wr_data}, {16'd0, 16'(first + 16'(i))});
      wr_data_rd = 1'b1;
      tick(1);
      wr_data_rd = 1'b0;
      if (alt) tick(1);
    end
  endtask

  task automatic run_burst(input string tag, input logic [21:0] addr, input logic [15:0] first);
    for (int i = 0; i < 8; i++) send_pixel(16'(first + 16'(i)));
    wait_req({tag, "_req"});
    check({tag, "_addr"}, {10'd0, wr_addr}, {10'd0, addr});
    grant({tag, "_ack"});
    pop_n({tag, "_data"}, first, 8, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    cmos_vsyn   = 1'b0;
    data_16b    = 16'h0000;
    data_16b_en = 1'b0;
    wr_ack      = 1'b0;
    wr_data_rd  = 1'b0;
    tick(2);

    // reset values
    check("rst_wr_req",     {31'd0, wr_req},     32'd0);
    check("rst_wr_addr",    {10'd0, wr_addr},    32'd0);
    check("rst_wr_data",    {16'd0, wr_data},    32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_rd_bank",    {31'd0, rd_bank},    32'd1);
    check("rst_ovf",        {31'd0, ovf},        32'd0);
    rst_n = 1'b1;
    tick(1);

    // pixels before the first frame start are ignored
    for (int i = 0; i < 10; i++) send_pixel(16'(16'hAA00 + 16'(i)));
    tick(3);
    check("pre_sof_no_req", {31'd0, wr_req}, 32'd0);

    // frame 1 (bank 0): pops in IDLE are ignored, then alternate-cycle pops
    vsync_pulse();
    for (int i = 0; i < 7; i++) send_pixel(16'(16'h0010 + 16'(i)));
    wr_data_rd = 1'b1;
    tick(2);
    wr_data_rd = 1'b0;
    check("idle_pop_head",   {16'd0, wr_data}, 32'h0010);
    check("idle_pop_no_req", {31'd0, wr_req},  32'd0);
    send_pixel(16'h0017);
    wait_req("f1b0_req");
    check("f1b0_addr", {10'd0, wr_addr}, 32'd0);
    grant("f1b0_ack");
    pop_n("f1b0_alt_data", 16'h0010, 8, 1'b1);
    check("f1b0_idle_req", {31'd0, wr_req}, 32'd0);
    check("f1b0_empty",    {16'd0, wr_data}, 32'd0);
    run_burst("f1b1", 22'd8,  16'h0018);
    run_burst("f1b2", 22'd16, 16'h0020);
    check("f1_no_early_done", {31'd0, frame_done}, 32'd0);
    run_burst("f1b3", 22'd24, 16'h0028);
    check("f1_done",    {31'd0, frame_done}, 32'd1);
    check("f1_rd_bank", {31'd0, rd_bank},    32'd0);
    tick(1);
    check("f1_done_pulse", {31'd0, frame_done}, 32'd0);

    // frame 2 (bank 1 base 1024)
    vsync_pulse();
    run_burst("f2b0", 22'd1024, 16'h0100);
    run_burst("f2b1", 22'd1032, 16'h0108);
    run_burst("f2b2", 22'd1040, 16'h0110);
    run_burst("f2b3", 22'd1048, 16'h0118);
    check("f2_done",    {31'd0, frame_done}, 32'd1);
    check("f2_rd_bank", {31'd0, rd_bank},    32'd1);

    // frame 3: grant withheld, FIFO of 16 overflows on the 17th pixel
    vsync_pulse();
    for (int i = 0; i < 16; i++) send_pixel(16'(16'h0300 + 16'(i)));
    check("ovf_16_clear", {31'd0, ovf}, 32'd0);
    send_pixel(16'h0310);
    check("ovf_17_set", {31'd0, ovf}, 32'd1);
    for (int i = 17; i < 20; i++) send_pixel(16'(16'h0300 + 16'(i)));
    check("ovf_req",  {31'd0, wr_req},  32'd1);
    check("ovf_addr", {10'd0, wr_addr}, 32'd0);
    grant("ovf_ack");
    pop_n("ovf_data", 16'h0300, 8, 1'b0);
    check("ovf_no_done", {31'd0, frame_done}, 32'd0);
    check("ovf_rd_bank", {31'd0, rd_bank},    32'd1);

    // frame 4: clean again, bank 0 still being written, then toggles
    vsync_pulse();
    run_burst("f4b0", 22'd0,  16'h0400);
    run_burst("f4b1", 22'd8,  16'h0408);
    run_burst("f4b2", 22'd16, 16'h0410);
    run_burst("f4b3", 22'd24, 16'h0418);
    check("f4_done",    {31'd0, frame_done}, 32'd1);
    check("f4_rd_bank", {31'd0, rd_bank},    32'd0);
    check("f4_ovf_sticky", {31'd0, ovf},     32'd1);

    // frame start during XFER: burst completes, then FIFO is flushed
    vsync_pulse();
    for (int i = 0; i < 12; i++) send_pixel(16'(16'h0500 + 16'(i)));
    wait_req("mid_req");
    check("mid_addr", {10'd0, wr_addr}, 32'd1024);
    grant("mid_ack");
    pop_n("mid_data_a", 16'h0500, 2, 1'b0);
    vsync_pulse();
    pop_n("mid_data_b", 16'h0502, 6, 1'b0);
    tick(1);
    check("mid_flushed", {16'd0, wr_data}, 32'd0);
    run_burst("mid_next", 22'd1024, 16'h0600);

    // asynchronous reset while requesting
    for (int i = 0; i < 8; i++) send_pixel(16'(16'h0700 + 16'(i)));
    wait_req("arst_req");
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_wr_req",  {31'd0, wr_req},  32'd0);
    check("arst_wr_addr", {10'd0, wr_addr}, 32'd0);
    check("arst_rd_bank", {31'd0, rd_bank}, 32'd1);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_pixel(16'(16'h0800 + 16'(i)));
    tick(3);
    check("arst_no_req", {31'd0, wr_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
